// File: rtl/spi_burst_pkg.sv
// Shared types and field positions for the SPI burst FIFO controller.
package spi_burst_pkg;

  // Flag positions above the command byte field: i_Data[BYTE_WIDTH + <flag>_BIT].
  localparam int unsigned LAST_BIT = 0;
  localparam int unsigned READ_BIT = 1;

  typedef enum logic [2:0] {
    StIdle,
    StStbSetup,
    StShift,
    StGap,
    StReadDelay,
    StRead,
    StStbHold,
    StStbIdle
  } spi_state_e;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with registered level; writes while full and reads while empty are ignored.
module sync_fifo #(
  parameter int unsigned WIDTH = 10,
  parameter int unsigned DEPTH = 4
) (
  input  logic                     i_Clk,
  input  logic                     i_Rst,
  input  logic                     i_Wr_En,
  input  logic [WIDTH-1:0]         i_Wr_Data,
  input  logic                     i_Rd_En,
  output logic [WIDTH-1:0]         o_Rd_Data,
  output logic                     o_Full,
  output logic                     o_Empty,
  output logic [$clog2(DEPTH):0]   o_Level
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0]   LEVEL_FULL = (AW + 1)'(DEPTH);
  localparam logic [AW:0]   LEVEL_ONE  = (AW + 1)'(1);
  localparam logic [AW-1:0] PTR_ONE    = AW'(1);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [AW:0]      r_level;
  logic             w_wr;
  logic             w_rd;

  // Full is judged on the registered level, so a pop in the same cycle never frees a slot.
  assign w_wr = i_Wr_En && (r_level != LEVEL_FULL);
  assign w_rd = i_Rd_En && (r_level != '0);

  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else begin
      if (w_wr) r_wr_ptr <= r_wr_ptr + PTR_ONE;
      if (w_rd) r_rd_ptr <= r_rd_ptr + PTR_ONE;
      if (w_wr && !w_rd)      r_level <= r_level + LEVEL_ONE;
      else if (!w_wr && w_rd) r_level <= r_level - LEVEL_ONE;
    end
  end

  always_ff @(posedge i_Clk) begin
    if (!i_Rst && w_wr) r_mem[r_wr_ptr] <= i_Wr_Data;
  end

  assign o_Rd_Data = r_mem[r_rd_ptr];
  assign o_Full    = (r_level == LEVEL_FULL);
  assign o_Empty   = (r_level == '0);
  assign o_Level   = r_level;

endmodule

// File: rtl/spi_burst_fifo.sv
// Queued SPI command engine: bytes are shifted LSB first under one strobe window per burst,
// with optional read-back of SPI_READ_WIDTH bits on the shared data line.
module spi_burst_fifo #(
  parameter int unsigned BYTE_WIDTH            = 8,
  parameter int unsigned FIFO_DEPTH            = 4,
  parameter int unsigned SPI_CYCLES            = 0,
  parameter int unsigned SPI_READ_DELAY_CYCLES = 0,
  parameter int unsigned SPI_READ_WIDTH        = 32
) (
  input  logic                          i_Clk,
  input  logic                          i_Rst,
  input  logic                          i_Data_Valid,
  input  logic [BYTE_WIDTH+1:0]         i_Data,
  output logic                          o_FIFO_Full,
  output logic [$clog2(FIFO_DEPTH):0]   o_FIFO_Level,
  output logic [SPI_READ_WIDTH-1:0]     o_Data,
  output logic                          o_Data_Valid,
  output logic                          o_Busy,
  output logic                          o_SPI_Stb,
  output logic                          o_SPI_Clk,
  inout  wire                           io_SPI_Dio
);
  import spi_burst_pkg::*;

  localparam int unsigned DW       = BYTE_WIDTH + 2;
  localparam int unsigned CNT_MAX  = (SPI_CYCLES > SPI_READ_DELAY_CYCLES) ? SPI_CYCLES
                                                                          : SPI_READ_DELAY_CYCLES;
  localparam int unsigned CNT_W    = $clog2(CNT_MAX + 2);
  localparam int unsigned BIT_MAX  = (BYTE_WIDTH > SPI_READ_WIDTH) ? BYTE_WIDTH : SPI_READ_WIDTH;
  localparam int unsigned BIT_W    = $clog2(BIT_MAX + 1);
  localparam int unsigned DLY_LAST_I = (SPI_READ_DELAY_CYCLES == 0) ? 0
                                                                    : SPI_READ_DELAY_CYCLES - 1;

  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(SPI_CYCLES);
  localparam logic [CNT_W-1:0] DLY_LAST  = CNT_W'(DLY_LAST_I);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [BIT_W-1:0] BYTE_LAST = BIT_W'(BYTE_WIDTH - 1);
  localparam logic [BIT_W-1:0] READ_LAST = BIT_W'(SPI_READ_WIDTH - 1);
  localparam logic [BIT_W-1:0] BIT_ONE   = BIT_W'(1);

  spi_state_e                r_state, w_state;
  logic [CNT_W-1:0]          r_cnt, w_cnt;
  logic                      r_phase, w_phase;
  logic [BIT_W-1:0]          r_bit, w_bit;
  logic [DW-1:0]             r_word, w_word;
  logic                      w_pop;
  logic                      w_done;
  logic                      w_empty;
  logic [DW-1:0]             w_rd_data;
  logic                      w_half_done;
  logic                      w_sample;
  logic [BYTE_WIDTH-1:0]     w_tx_shifted;
  logic [SPI_READ_WIDTH-1:0] w_rx_next;

  logic                      r_stb;
  logic                      r_sclk;
  logic                      r_oe;
  logic                      r_dio;
  logic [SPI_READ_WIDTH-1:0] r_rx;
  logic [SPI_READ_WIDTH-1:0] r_data;
  logic                      r_data_valid;

  sync_fifo #(
    .WIDTH (DW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .i_Clk     (i_Clk),
    .i_Rst     (i_Rst),
    .i_Wr_En   (i_Data_Valid),
    .i_Wr_Data (i_Data),
    .i_Rd_En   (w_pop),
    .o_Rd_Data (w_rd_data),
    .o_Full    (o_FIFO_Full),
    .o_Empty   (w_empty),
    .o_Level   (o_FIFO_Level)
  );

  assign w_half_done  = (r_cnt == HALF_LAST);
  assign w_tx_shifted = r_word[BYTE_WIDTH-1:0] >> r_bit;
  // First cycle of a READ high phase: the registered clock rises on this same edge.
  assign w_sample     = (r_state == StRead) && r_phase && (r_cnt == '0);
  assign w_rx_next    = w_sample ? {io_SPI_Dio, r_rx[SPI_READ_WIDTH-1:1]} : r_rx;

  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      r_state <= StIdle;
      r_cnt   <= '0;
      r_phase <= 1'b0;
      r_bit   <= '0;
      r_word  <= '0;
    end else begin
      r_state <= w_state;
      r_cnt   <= w_cnt;
      r_phase <= w_phase;
      r_bit   <= w_bit;
      r_word  <= w_word;
    end
  end

  always_comb begin
    w_state = r_state;
    w_cnt   = r_cnt;
    w_phase = r_phase;
    w_bit   = r_bit;
    w_word  = r_word;
    w_pop   = 1'b0;
    w_done  = 1'b0;
    unique case (r_state)
      StIdle: begin
        if (!w_empty) begin
          w_pop   = 1'b1;
          w_word  = w_rd_data;
          w_state = StStbSetup;
          w_cnt   = '0;
        end
      end
      StStbSetup: begin
        if (w_half_done) begin
          w_state = StShift;
          w_cnt   = '0;
          w_phase = 1'b0;
          w_bit   = '0;
        end else begin
          w_cnt = r_cnt + CNT_ONE;
        end
      end
      StShift: begin
        if (!w_half_done) begin
          w_cnt = r_cnt + CNT_ONE;
        end else begin
          w_cnt   = '0;
          w_phase = !r_phase;
          if (r_phase) begin
            if (r_bit == BYTE_LAST) begin
              w_bit = '0;
              if (r_word[BYTE_WIDTH + READ_BIT]) begin
                if (SPI_READ_DELAY_CYCLES == 0) w_state = StRead;
                else                            w_state = StReadDelay;
              end else if (r_word[BYTE_WIDTH + LAST_BIT]) begin
                w_state = StStbHold;
              end else begin
                w_state = StGap;
              end
            end else begin
              w_bit = r_bit + BIT_ONE;
            end
          end
        end
      end
      StGap: begin
        // Counter saturates at the half-period so the strobe window can stall indefinitely.
        if (!w_half_done) begin
          w_cnt = r_cnt + CNT_ONE;
        end else if (!w_empty) begin
          w_pop   = 1'b1;
          w_word  = w_rd_data;
          w_state = StShift;
          w_cnt   = '0;
          w_phase = 1'b0;
          w_bit   = '0;
        end
      end
      StReadDelay: begin
        if (r_cnt == DLY_LAST) begin
          w_state = StRead;
          w_cnt   = '0;
          w_phase = 1'b0;
          w_bit   = '0;
        end else begin
          w_cnt = r_cnt + CNT_ONE;
        end
      end
      StRead: begin
        if (!w_half_done) begin
          w_cnt = r_cnt + CNT_ONE;
        end else begin
          w_cnt   = '0;
          w_phase = !r_phase;
          if (r_phase) begin
            if (r_bit == READ_LAST) begin
              w_done  = 1'b1;
              w_bit   = '0;
              w_state = StStbHold;
            end else begin
              w_bit = r_bit + BIT_ONE;
            end
          end
        end
      end
      StStbHold: begin
        if (w_half_done) begin
          w_state = StStbIdle;
          w_cnt   = '0;
        end else begin
          w_cnt = r_cnt + CNT_ONE;
        end
      end
      StStbIdle: begin
        if (w_half_done) begin
          w_state = StIdle;
          w_cnt   = '0;
        end else begin
          w_cnt = r_cnt + CNT_ONE;
        end
      end
      default: w_state = StIdle;
    endcase
  end

  // SPI pins are a registered decode of the current state, one cycle behind it.
  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      r_stb        <= 1'b1;
      r_sclk       <= 1'b1;
      r_oe         <= 1'b0;
      r_dio        <= 1'b0;
      r_rx         <= '0;
      r_data       <= '0;
      r_data_valid <= 1'b0;
    end else begin
      r_stb        <= (r_state == StIdle) || (r_state == StStbIdle);
      r_sclk       <= !(((r_state == StShift) || (r_state == StRead)) && !r_phase);
      r_oe         <= (r_state == StShift);
      r_dio        <= w_tx_shifted[0];
      r_rx         <= w_rx_next;
      r_data_valid <= w_done;
      if (w_done) r_data <= w_rx_next;
    end
  end

  assign io_SPI_Dio   = r_oe ? r_dio : 1'bz;
  assign o_SPI_Stb    = r_stb;
  assign o_SPI_Clk    = r_sclk;
  assign o_Data       = r_data;
  assign o_Data_Valid = r_data_valid;
  assign o_Busy       = (r_state != StIdle);

endmodule
